// File: rtl/pixel_dispatcher_pkg.sv
// Shared types and constants for the pixel dispatcher and its round-robin arbiter.
package pixel_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    DONE
  } dispatch_state_e;

  localparam int unsigned DEFAULT_SCREEN_WIDTH  = 640;
  localparam int unsigned DEFAULT_SCREEN_HEIGHT = 480;
  localparam int unsigned PIXELS_PER_FRAME      = DEFAULT_SCREEN_WIDTH * DEFAULT_SCREEN_HEIGHT;

  function automatic int unsigned pixels_per_frame(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PTR_W'((32'(ptr) + k) % N);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_dispatcher.sv
// Hands out raster-scan pixel coordinates to a pool of compute engines, one pixel per engine start,
// with a frame-level start/busy/done handshake, pause, and selectable vertical scan direction.
module pixel_dispatcher
  import pixel_dispatch_pkg::*;
#(
  parameter int unsigned COORD_WIDTH   = 11,
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned SCREEN_HEIGHT = 480,
  parameter int unsigned NUM_ENGINES   = 4,
  parameter int unsigned Y_DOWN        = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   pause,
  input  logic [NUM_ENGINES-1:0] engine_ready,
  output logic [NUM_ENGINES-1:0] engine_start,
  output logic [COORD_WIDTH-1:0] xcoord [NUM_ENGINES],
  output logic [COORD_WIDTH-1:0] ycoord [NUM_ENGINES],
  output logic                   busy,
  output logic                   frame_done,
  output logic [31:0]            pixels_issued
);

  localparam int unsigned PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [COORD_WIDTH-1:0] X_LAST  = COORD_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] Y_FIRST = COORD_WIDTH'((Y_DOWN != 0) ? SCREEN_HEIGHT - 1 : 0);
  localparam logic [COORD_WIDTH-1:0] Y_LAST  = COORD_WIDTH'((Y_DOWN != 0) ? 0 : SCREEN_HEIGHT - 1);

  // Parameter sanity checks at elaboration
  if (NUM_ENGINES < 1 || NUM_ENGINES > 16) begin : g_bad_engines
    $error("pixel_dispatcher: NUM_ENGINES must be 1..16");
  end
  if (64'(SCREEN_WIDTH) > (64'd1 << COORD_WIDTH) || SCREEN_WIDTH < 1) begin : g_bad_width
    $error("pixel_dispatcher: SCREEN_WIDTH does not fit COORD_WIDTH");
  end
  if (64'(SCREEN_HEIGHT) > (64'd1 << COORD_WIDTH) || SCREEN_HEIGHT < 1) begin : g_bad_height
    $error("pixel_dispatcher: SCREEN_HEIGHT does not fit COORD_WIDTH");
  end
  if (Y_DOWN > 1) begin : g_bad_ydown
    $error("pixel_dispatcher: Y_DOWN must be 0 or 1");
  end

  dispatch_state_e          state_q, state_d;
  logic [COORD_WIDTH-1:0]   x_q, y_q;
  logic [PTR_W-1:0]         rr_ptr_q;
  logic [PTR_W-1:0]         gnt_idx;
  logic [PTR_W-1:0]         next_ptr;
  logic [NUM_ENGINES-1:0]   engine_start_q;
  logic [NUM_ENGINES-1:0]   arb_req;
  logic [NUM_ENGINES-1:0]   arb_gnt;
  logic                     arb_valid;
  logic                     last_pixel;
  logic [COORD_WIDTH-1:0]   xcoord_q [NUM_ENGINES];
  logic [COORD_WIDTH-1:0]   ycoord_q [NUM_ENGINES];
  logic                     busy_q;
  logic                     frame_done_q;
  logic [31:0]              pixels_q;

  // An engine granted last cycle may still show ready; mask it so it is not granted twice
  assign arb_req = (state_q == DISPATCH && !pause) ? (engine_ready & ~engine_start_q) : '0;

  rr_arbiter #(.N(NUM_ENGINES)) u_arb (
    .req   (arb_req),
    .ptr   (rr_ptr_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
      if (arb_gnt[i]) gnt_idx = PTR_W'(i);
    end
  end

  assign next_ptr = (gnt_idx == PTR_W'(NUM_ENGINES - 1)) ? '0 : gnt_idx + PTR_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (frame_start) state_d = DISPATCH;
      DISPATCH: if (arb_valid && last_pixel) state_d = DRAIN;
      DRAIN:    if ((&engine_ready) && (engine_start_q == '0)) state_d = DONE;
      DONE:     state_d = IDLE;
    endcase
  end

  // Scan counters, round-robin pointer, per-engine coordinates and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      engine_start_q <= '0;
      x_q            <= '0;
      y_q            <= Y_FIRST;
      rr_ptr_q       <= '0;
      pixels_q       <= '0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
        xcoord_q[i] <= '0;
        ycoord_q[i] <= '0;
      end
    end else begin
      engine_start_q <= arb_gnt;
      busy_q         <= (state_d != IDLE);
      frame_done_q   <= (state_d == DONE);
      if (state_q == IDLE && frame_start) begin
        x_q      <= '0;
        y_q      <= Y_FIRST;
        pixels_q <= '0;
      end else if (arb_valid) begin
        for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
          if (arb_gnt[i]) begin
            xcoord_q[i] <= x_q;
            ycoord_q[i] <= y_q;
          end
        end
        rr_ptr_q <= next_ptr;
        pixels_q <= pixels_q + 32'd1;
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= (Y_DOWN != 0) ? y_q - COORD_WIDTH'(1) : y_q + COORD_WIDTH'(1);
        end else begin
          x_q <= x_q + COORD_WIDTH'(1);
        end
      end
    end
  end

  assign engine_start  = engine_start_q;
  assign xcoord        = xcoord_q;
  assign ycoord        = ycoord_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign pixels_issued = pixels_q;

endmodule
